// File: rtl/ysyx_22040365_rf_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter: requester ids,
// default widths and the hard-wired zero register index.
package ysyx_22040365_rf_wb_arbiter_pkg;

    typedef enum logic {
        GRANT_EXU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int X0_IDX         = 0;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GRANT_EXU) ? GRANT_LSU : GRANT_EXU;
    endfunction

endpackage

// File: rtl/ysyx_22040365_rf_wb_arbiter_if.sv
// Writeback bus between EXU/LSU/decode and the regfile arbiter.
// Forwarding signals exist only when YSYX_22040365_RF_BYPASS_EN is defined.
interface ysyx_22040365_rf_wb_arbiter_if
    import ysyx_22040365_rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  exu_valid;
    logic [ADDR_WIDTH-1:0] exu_waddr;
    logic [DATA_WIDTH-1:0] exu_wdata;
    logic                  exu_ready;

    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_waddr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic                  lsu_ready;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

`ifdef YSYX_22040365_RF_BYPASS_EN
    logic                  rs1_fwd_valid;
    logic [DATA_WIDTH-1:0] rs1_fwd_data;
    logic                  rs2_fwd_valid;
    logic [DATA_WIDTH-1:0] rs2_fwd_data;
`endif

    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        input  exu_ready,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  lsu_ready,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  rf_wen, rf_waddr, rf_wdata
`ifdef YSYX_22040365_RF_BYPASS_EN
        , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );

    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        output exu_ready,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output lsu_ready,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output rf_wen, rf_waddr, rf_wdata
`ifdef YSYX_22040365_RF_BYPASS_EN
        , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/ysyx_22040365_rf_scoreboard.sv
// Busy bits for destination registers with loads in flight.
// YSYX_22040365_RF_BYPASS_EN masks a busy bit in the cycle its load is written back.
module ysyx_22040365_rf_scoreboard
    import ysyx_22040365_rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(X0_IDX);

    logic [DEPTH-1:0] busy;

    // Set is applied after clear so a newly issued load supersedes a retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en)
                busy[clr_idx] <= 1'b0;
            if (set_en && set_idx != ZERO_IDX)
                busy[set_idx] <= 1'b1;
        end
    end

    logic rs1_raw;
    logic rs2_raw;

    always_comb begin
        rs1_raw = (rs1_addr != ZERO_IDX) && busy[rs1_addr];
        rs2_raw = (rs2_addr != ZERO_IDX) && busy[rs2_addr];
    end

`ifdef YSYX_22040365_RF_BYPASS_EN
    always_comb begin
        rs1_busy = rs1_raw && !(clr_en && clr_idx == rs1_addr);
        rs2_busy = rs2_raw && !(clr_en && clr_idx == rs2_addr);
    end
`else
    always_comb begin
        rs1_busy = rs1_raw;
        rs2_busy = rs2_raw;
    end
`endif

endmodule

// File: rtl/ysyx_22040365_rf_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port (EXU vs LSU) with a
// registered output stage; optional forwarding under YSYX_22040365_RF_BYPASS_EN.
module ysyx_22040365_rf_wb_arbiter
    import ysyx_22040365_rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_22040365_rf_wb_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(X0_IDX);

    grant_e                last_grant;
    logic                  exu_grant;
    logic                  lsu_grant;
    logic                  exu_fire;
    logic                  lsu_fire;

    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        exu_grant = bus.exu_valid &&
                    (!bus.lsu_valid || other_grant(last_grant) == GRANT_EXU);
        lsu_grant = bus.lsu_valid &&
                    (!bus.exu_valid || other_grant(last_grant) == GRANT_LSU);
        exu_fire  = exu_grant && !rst;
        lsu_fire  = lsu_grant && !rst;
    end

    assign bus.exu_ready = exu_fire;
    assign bus.lsu_ready = lsu_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_EXU;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (exu_fire) begin
            last_grant <= GRANT_EXU;
            rf_wen_q   <= (bus.exu_waddr != ZERO_IDX);
            rf_waddr_q <= bus.exu_waddr;
            rf_wdata_q <= bus.exu_wdata;
        end else if (lsu_fire) begin
            last_grant <= GRANT_LSU;
            rf_wen_q   <= (bus.lsu_waddr != ZERO_IDX);
            rf_waddr_q <= bus.lsu_waddr;
            rf_wdata_q <= bus.lsu_wdata;
        end else begin
            rf_wen_q   <= 1'b0;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    ysyx_22040365_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.issue_valid),
        .set_idx  (bus.issue_rd),
        .clr_en   (lsu_fire),
        .clr_idx  (bus.lsu_waddr),
        .rs1_addr (bus.rs1_addr),
        .rs2_addr (bus.rs2_addr),
        .rs1_busy (bus.rs1_busy),
        .rs2_busy (bus.rs2_busy)
    );

`ifdef YSYX_22040365_RF_BYPASS_EN
    assign bus.rs1_fwd_valid = rf_wen_q && rf_waddr_q == bus.rs1_addr && bus.rs1_addr != ZERO_IDX;
    assign bus.rs2_fwd_valid = rf_wen_q && rf_waddr_q == bus.rs2_addr && bus.rs2_addr != ZERO_IDX;
    assign bus.rs1_fwd_data  = rf_wdata_q;
    assign bus.rs2_fwd_data  = rf_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_22040365_rf_wb_arbiter.sv
// Directed self-checking bench for the regfile writeback arbiter.
module tb_ysyx_22040365_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ysyx_22040365_rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    ysyx_22040365_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst             = 1'b1;
        bus.exu_valid   = 1'b0;
        bus.exu_waddr   = '0;
        bus.exu_wdata   = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_waddr   = '0;
        bus.lsu_wdata   = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;

        // Reset state and no grant while in reset
        tick();
        bus.exu_valid = 1'b1;
        settle();
        chk("rst_exu_ready", 64'(bus.exu_ready), 64'd0);
        tick();
        chk("rst_rf_wen",   64'(bus.rf_wen),   64'd0);
        chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_rf_wdata", bus.rf_wdata,      64'd0);
        bus.exu_valid = 1'b0;
        rst = 1'b0;

        // Single EXU write
        bus.exu_valid = 1'b1;
        bus.exu_waddr = 5'd3;
        bus.exu_wdata = 64'hAA;
        settle();
        chk("t1_exu_ready", 64'(bus.exu_ready), 64'd1);
        chk("t1_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        bus.exu_valid = 1'b0;
        settle();
        chk("t1_rf_wen",   64'(bus.rf_wen),   64'd1);
        chk("t1_rf_waddr", 64'(bus.rf_waddr), 64'd3);
        chk("t1_rf_wdata", bus.rf_wdata,      64'hAA);
        tick();
        chk("t1_rf_wen_off",  64'(bus.rf_wen),   64'd0);
        chk("t1_waddr_hold",  64'(bus.rf_waddr), 64'd3);
        chk("t1_wdata_hold",  bus.rf_wdata,      64'hAA);

        // Contention: LSU, EXU, LSU, EXU
        bus.exu_valid = 1'b1;
        bus.exu_waddr = 5'd1;
        bus.exu_wdata = 64'h11;
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd2;
        bus.lsu_wdata = 64'h22;
        settle();
        chk("rr0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        chk("rr0_exu_ready", 64'(bus.exu_ready), 64'd0);
        tick();
        chk("rr1_rf_waddr",  64'(bus.rf_waddr), 64'd2);
        chk("rr1_rf_wdata",  bus.rf_wdata,      64'h22);
        chk("rr1_exu_ready", 64'(bus.exu_ready), 64'd1);
        chk("rr1_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        chk("rr2_rf_waddr",  64'(bus.rf_waddr), 64'd1);
        chk("rr2_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        chk("rr3_rf_waddr",  64'(bus.rf_waddr), 64'd2);
        chk("rr3_exu_ready", 64'(bus.exu_ready), 64'd1);
        tick();
        bus.exu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        settle();
        chk("rr4_rf_waddr",  64'(bus.rf_waddr), 64'd1);
        chk("rr4_rf_wen",    64'(bus.rf_wen),   64'd1);
        tick();
        chk("rr5_rf_wen",    64'(bus.rf_wen),   64'd0);

        // Load scoreboard: issue rd=5, write back via LSU
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        bus.rs1_addr    = 5'd5;
        settle();
        chk("sb_busy_before", 64'(bus.rs1_busy), 64'd0);
        tick();
        bus.issue_valid = 1'b0;
        settle();
        chk("sb_busy_set", 64'(bus.rs1_busy), 64'd1);
        tick();
        chk("sb_busy_hold", 64'(bus.rs1_busy), 64'd1);
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd5;
        bus.lsu_wdata = 64'h55;
        settle();
        chk("sb_lsu_ready", 64'(bus.lsu_ready), 64'd1);
`ifdef YSYX_22040365_RF_BYPASS_EN
        chk("sb_busy_masked", 64'(bus.rs1_busy), 64'd0);
`else
        chk("sb_busy_until_edge", 64'(bus.rs1_busy), 64'd1);
`endif
        tick();
        bus.lsu_valid = 1'b0;
        settle();
        chk("sb_busy_cleared", 64'(bus.rs1_busy), 64'd0);
        chk("sb_rf_waddr",     64'(bus.rf_waddr), 64'd5);
        chk("sb_rf_wdata",     bus.rf_wdata,      64'h55);
`ifdef YSYX_22040365_RF_BYPASS_EN
        chk("sb_fwd_valid", 64'(bus.rs1_fwd_valid), 64'd1);
        chk("sb_fwd_data",  bus.rs1_fwd_data,       64'h55);
`endif
        tick();

        // Same-cycle set and clear of index 7: set wins
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.lsu_valid   = 1'b1;
        bus.lsu_waddr   = 5'd7;
        bus.lsu_wdata   = 64'h77;
        bus.rs2_addr    = 5'd7;
        settle();
        chk("sc_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.lsu_valid   = 1'b0;
        settle();
        chk("sc_busy7", 64'(bus.rs2_busy), 64'd1);
        tick();

        // x0 write and x0 issue
        bus.exu_valid   = 1'b1;
        bus.exu_waddr   = 5'd0;
        bus.exu_wdata   = 64'hFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.rs1_addr    = 5'd0;
        settle();
        chk("x0_exu_ready", 64'(bus.exu_ready), 64'd1);
        tick();
        bus.exu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
        settle();
        chk("x0_rf_wen",  64'(bus.rf_wen),   64'd0);
        chk("x0_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        tick();

        // Reset mid-operation
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        bus.rs1_addr    = 5'd4;
        tick();
        bus.issue_valid = 1'b0;
        settle();
        chk("mr_busy4_set", 64'(bus.rs1_busy), 64'd1);
        tick();
        bus.lsu_valid = 1'b1;
        bus.lsu_waddr = 5'd9;
        bus.lsu_wdata = 64'h99;
        rst = 1'b1;
        settle();
        chk("mr_lsu_ready_rst", 64'(bus.lsu_ready), 64'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("mr_busy4_clr", 64'(bus.rs1_busy),  64'd0);
        chk("mr_busy7_clr", 64'(bus.rs2_busy),  64'd0);
        chk("mr_rf_wen",    64'(bus.rf_wen),    64'd0);
        chk("mr_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        tick();
        bus.lsu_valid = 1'b0;
        settle();
        chk("mr_rf_wen_after", 64'(bus.rf_wen),   64'd1);
        chk("mr_rf_waddr",     64'(bus.rf_waddr), 64'd9);
        chk("mr_rf_wdata",     bus.rf_wdata,      64'h99);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
